// File: rtl/alu_scan_ctrl_if.sv
// Bundles the control handshake and the shared ALU bus of the scan sequencer.
//   master: the sequencer (receives start/config and ALU results, drives ALU
//           stimulus and scan status/results)
//   slave : the harness side (drives start/config and ALU results, observes
//           stimulus and status)
interface alu_scan_ctrl_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             start;
    logic             mode;
    logic [CNT_W-1:0] num_vec;
    logic [15:0]      seed;
    logic [3:0]       y_clean;
    logic [3:0]       y_trojan;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [1:0]       alu_op;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             first_fail_valid;
    logic [9:0]       first_fail_vec;

    modport master (
        input  start, mode, num_vec, seed, y_clean, y_trojan,
        output alu_a, alu_b, alu_op, busy, done, vec_count, mismatch_cnt,
               first_fail_valid, first_fail_vec
    );

    modport slave (
        output start, mode, num_vec, seed, y_clean, y_trojan,
        input  alu_a, alu_b, alu_op, busy, done, vec_count, mismatch_cnt,
               first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/alu_scan_ctrl.sv
// Scan sequencer for a clean/trojan ALU pair. Drives {op,B,A} vectors onto the
// shared ALU bus (exhaustive 0..1023 or 16-bit Galois LFSR), waits SETTLE_CYC
// cycles, compares the two ALU results and accumulates vector/mismatch counts
// plus the first failing vector.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - alu_scan_ctrl_if.master: start/mode/num_vec/seed and y_clean/y_trojan
//           in; alu_a/alu_b/alu_op, busy, done, vec_count, mismatch_cnt,
//           first_fail_valid, first_fail_vec out (all registered)
module alu_scan_ctrl #(
    parameter int unsigned SETTLE_CYC   = 2,
    parameter int unsigned CNT_W        = 16,
    parameter logic [15:0] LFSR_DEFAULT = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_scan_ctrl_if.master bus
);
    localparam int unsigned       VEC_W     = 10;
    localparam int unsigned       LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
    localparam logic [CNT_W-1:0]  EXH_TOTAL = CNT_W'(1024);
    localparam int unsigned       SET_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   num_vec_q, num_vec_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [VEC_W-1:0]   exh_q, exh_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [3:0]         alu_a_q, alu_a_d;
    logic [3:0]         alu_b_q, alu_b_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   vec_count_q, vec_count_d;
    logic [CNT_W-1:0]   mismatch_cnt_q, mismatch_cnt_d;
    logic               ffv_q, ffv_d;
    logic [VEC_W-1:0]   ffvec_q, ffvec_d;

    logic [VEC_W-1:0]   vec_c;
    logic [CNT_W-1:0]   total_c;
    logic [CNT_W-1:0]   vc_inc_c;
    logic [LFSR_W-1:0]  lfsr_next_c;
    logic               miss_c;

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            mode_q         <= 1'b0;
            num_vec_q      <= '0;
            lfsr_q         <= LFSR_DEFAULT;
            exh_q          <= '0;
            settle_q       <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            vec_count_q    <= '0;
            mismatch_cnt_q <= '0;
            ffv_q          <= 1'b0;
            ffvec_q        <= '0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            num_vec_q      <= num_vec_d;
            lfsr_q         <= lfsr_d;
            exh_q          <= exh_d;
            settle_q       <= settle_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            vec_count_q    <= vec_count_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            ffv_q          <= ffv_d;
            ffvec_q        <= ffvec_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        num_vec_d      = num_vec_q;
        lfsr_d         = lfsr_q;
        exh_d          = exh_q;
        settle_d       = settle_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        busy_d         = busy_q;
        done_d         = done_q;
        vec_count_d    = vec_count_q;
        mismatch_cnt_d = mismatch_cnt_q;
        ffv_d          = ffv_q;
        ffvec_d        = ffvec_q;

        vec_c       = mode_q ? lfsr_q[VEC_W-1:0] : exh_q;
        total_c     = mode_q ? num_vec_q : EXH_TOTAL;
        vc_inc_c    = vec_count_q + CNT_W'(1);
        lfsr_next_c = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : '0);
        // Case inequality so an X/Z result from either ALU is flagged
        miss_c      = (bus.y_clean !== bus.y_trojan);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d        = S_LOAD;
                    mode_d         = bus.mode;
                    num_vec_d      = bus.num_vec;
                    lfsr_d         = (bus.seed == '0) ? LFSR_DEFAULT : bus.seed;
                    exh_d          = '0;
                    busy_d         = 1'b1;
                    done_d         = 1'b0;
                    vec_count_d    = '0;
                    mismatch_cnt_d = '0;
                    ffv_d          = 1'b0;
                    ffvec_d        = '0;
                end
            end
            S_LOAD: begin
                if (total_c == '0) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                alu_a_d  = vec_c[3:0];
                alu_b_d  = vec_c[7:4];
                alu_op_d = vec_c[9:8];
                settle_d = '0;
                state_d  = (SETTLE_CYC > 0) ? S_SETTLE : S_CHECK;
            end
            S_SETTLE: begin
                if (settle_q == SET_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_CHECK: begin
                vec_count_d = vc_inc_c;
                if (miss_c) begin
                    if (mismatch_cnt_q != '1) begin
                        mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
                    end
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec_c;
                    end
                end
                exh_d  = exh_q + VEC_W'(1);
                lfsr_d = lfsr_next_c;
                if (vc_inc_c == total_c) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.alu_a            = alu_a_q;
    assign bus.alu_b            = alu_b_q;
    assign bus.alu_op           = alu_op_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.vec_count        = vec_count_q;
    assign bus.mismatch_cnt     = mismatch_cnt_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;
endmodule

// File: tb/tb_alu_scan_ctrl.sv
// Bench for alu_scan_ctrl: two instances (SETTLE_CYC=2 and SETTLE_CYC=0) share
// one stimulus stream; a timeline model predicts every output each cycle.
module tb_alu_scan_ctrl;
    localparam int unsigned CNT_W = 16;
    localparam int          NDUT  = 2;
    localparam int          S0    = 2;
    localparam int          S1    = 0;
    localparam int          NONE  = 1 << 30;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        mode    = 1'b0;
    logic [15:0] num_vec = '0;
    logic [15:0] seed    = '0;
    int          troj_kind = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Reference ALU and trojan variants
    function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [3:0] alu_troj(input int kind, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] y;
        y = alu_ref(op, a, b);
        if (kind == 1 && a == 4'hF && b == 4'hF && op == 2'd0) y[0] = ~y[0];
        if (kind == 2 && op == 2'd3 && a[0]) y = y ^ 4'h8;
        return y;
    endfunction

    alu_scan_ctrl_if #(.CNT_W(CNT_W)) bus0 ();
    alu_scan_ctrl_if #(.CNT_W(CNT_W)) bus1 ();

    alu_scan_ctrl #(.SETTLE_CYC(S0), .CNT_W(CNT_W), .LFSR_DEFAULT(16'hACE1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    alu_scan_ctrl #(.SETTLE_CYC(S1), .CNT_W(CNT_W), .LFSR_DEFAULT(16'hACE1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    assign bus0.start    = start;
    assign bus0.mode     = mode;
    assign bus0.num_vec  = num_vec;
    assign bus0.seed     = seed;
    assign bus0.y_clean  = alu_ref(bus0.alu_op, bus0.alu_a, bus0.alu_b);
    assign bus0.y_trojan = alu_troj(troj_kind, bus0.alu_op, bus0.alu_a, bus0.alu_b);
    assign bus1.start    = start;
    assign bus1.mode     = mode;
    assign bus1.num_vec  = num_vec;
    assign bus1.seed     = seed;
    assign bus1.y_clean  = alu_ref(bus1.alu_op, bus1.alu_a, bus1.alu_b);
    assign bus1.y_trojan = alu_troj(troj_kind, bus1.alu_op, bus1.alu_a, bus1.alu_b);

    logic [9:0]       d_alu   [NDUT];
    logic             d_busy  [NDUT];
    logic             d_done  [NDUT];
    logic [CNT_W-1:0] d_vc    [NDUT];
    logic [CNT_W-1:0] d_mm    [NDUT];
    logic             d_ffv   [NDUT];
    logic [9:0]       d_ffvec [NDUT];

    assign d_alu[0]   = {bus0.alu_op, bus0.alu_b, bus0.alu_a};
    assign d_busy[0]  = bus0.busy;
    assign d_done[0]  = bus0.done;
    assign d_vc[0]    = bus0.vec_count;
    assign d_mm[0]    = bus0.mismatch_cnt;
    assign d_ffv[0]   = bus0.first_fail_valid;
    assign d_ffvec[0] = bus0.first_fail_vec;
    assign d_alu[1]   = {bus1.alu_op, bus1.alu_b, bus1.alu_a};
    assign d_busy[1]  = bus1.busy;
    assign d_done[1]  = bus1.done;
    assign d_vc[1]    = bus1.vec_count;
    assign d_mm[1]    = bus1.mismatch_cnt;
    assign d_ffv[1]   = bus1.first_fail_valid;
    assign d_ffvec[1] = bus1.first_fail_vec;

    // Model: per instance, the vector list of the current run, a prefix count
    // of mismatches, and the number of clock edges since the accepted start.
    logic [9:0] mvec   [NDUT][1024];
    int         mpref  [NDUT][1025];
    int         mfirst [NDUT];
    int         mtotal [NDUT];
    int         me     [NDUT];
    bit         mact   [NDUT];
    logic [9:0] mhold  [NDUT];
    bit         chk_en = 1'b0;

    function automatic int per_vec(input int d);
        return 2 + ((d == 0) ? S0 : S1);
    endfunction

    function automatic int run_len(input int d);
        return 2 + mtotal[d] * per_vec(d);
    endfunction

    function automatic logic [9:0] exp_alu(input int d);
        int nd;
        if (!mact[d]) return 10'h000;
        nd = (me[d] < 3) ? 0 : (me[d] - 3) / per_vec(d) + 1;
        if (nd > mtotal[d]) nd = mtotal[d];
        return (nd == 0) ? mhold[d] : mvec[d][nd-1];
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic build(input int d);
        logic [15:0] l;
        logic [9:0]  v;
        int          t;
        bit          mm;
        mhold[d]    = exp_alu(d);
        t           = mode ? int'(num_vec) : 1024;
        mtotal[d]   = t;
        l           = (seed == 16'h0) ? 16'hACE1 : seed;
        mpref[d][0] = 0;
        mfirst[d]   = NONE;
        for (int k = 0; k < t; k++) begin
            v  = mode ? l[9:0] : 10'(k);
            mvec[d][k] = v;
            mm = alu_ref(v[9:8], v[3:0], v[7:4]) != alu_troj(troj_kind, v[9:8], v[3:0], v[7:4]);
            mpref[d][k+1] = mpref[d][k] + (mm ? 1 : 0);
            if (mm && mfirst[d] == NONE) mfirst[d] = k;
            l = lfsr_step(l);
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (!rst_n) begin
                mact[d] = 1'b0;
            end else if (start && (!mact[d] || me[d] >= run_len(d))) begin
                build(d);
                mact[d] = 1'b1;
                me[d]   = 1;
            end else if (mact[d] && me[d] < 1000000) begin
                me[d] = me[d] + 1;
            end
        end
        chk_en = 1'b1;
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d t=%0t got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin : cmp
        int         t, vc;
        logic       eb;
        logic [9:0] effvec;
        logic       effv;
        if (chk_en) begin
            for (int d = 0; d < NDUT; d++) begin
                if (!mact[d]) begin
                    eb = 1'b0;
                    vc = 0;
                    t  = 0;
                end else begin
                    t  = mtotal[d];
                    eb = (me[d] < run_len(d));
                    vc = (me[d] < 2) ? 0 : (me[d] - 2) / per_vec(d);
                    if (vc > t) vc = t;
                end
                effv   = mact[d] && (mfirst[d] < vc);
                effvec = effv ? mvec[d][mfirst[d]] : 10'h000;
                chk("busy",  d, 32'(d_busy[d]),  32'(eb));
                chk("done",  d, 32'(d_done[d]),  32'(mact[d] && !eb));
                chk("alu",   d, 32'(d_alu[d]),   32'(exp_alu(d)));
                chk("vec_count", d, 32'(d_vc[d]), 32'(vc));
                chk("mismatch_cnt", d, 32'(d_mm[d]), mact[d] ? 32'(mpref[d][vc]) : 32'd0);
                chk("ffv",   d, 32'(d_ffv[d]),   32'(effv));
                chk("ffvec", d, 32'(d_ffvec[d]), 32'(effvec));
            end
        end
    end

    task automatic pulse_start(input logic m, input logic [15:0] nv, input logic [15:0] sd);
        @(negedge clk);
        start   = 1'b1;
        mode    = m;
        num_vec = nv;
        seed    = sd;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Waits for done on instance d, scrambling config inputs meanwhile
    task automatic wait_done(input int d, input int n0, output int n);
        n = n0;
        while (d_done[d] !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
            mode    = 1'($urandom);
            num_vec = 16'($urandom_range(0, 40));
            seed    = 16'($urandom);
        end
        chk("done_timeout", d, 32'(d_done[d]), 32'd1);
    endtask

    task automatic wait_both();
        int n;
        wait_done(0, 1, n);
        wait_done(1, 1, n);
    endtask

    initial begin : guard
        #5000000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_vc", 0, 32'(d_vc[0]), 32'd0);
        chk("reset_alu", 1, 32'(d_alu[1]), 32'd0);

        // Random, zero vectors: straight to done, ALU bus never moves
        pulse_start(1'b1, 16'd0, 16'h1234);
        @(negedge clk);
        chk("nv0_done", 0, 32'(d_done[0]), 32'd1);
        chk("nv0_alu", 0, 32'(d_alu[0]), 32'd0);
        chk("nv0_alu", 1, 32'(d_alu[1]), 32'd0);

        // Exhaustive, trojan on A=F,B=F,op=0
        troj_kind = 1;
        pulse_start(1'b0, 16'd0, 16'd0);
        wait_done(0, 1, n);
        chk("exh_latency", 0, 32'(n), 32'd4098);
        chk("exh_vc", 0, 32'(d_vc[0]), 32'd1024);
        chk("exh_mm", 0, 32'(d_mm[0]), 32'd1);
        chk("exh_ffv", 0, 32'(d_ffv[0]), 32'd1);
        chk("exh_ffvec", 0, 32'(d_ffvec[0]), 32'h0FF);
        chk("exh_ffvec", 1, 32'(d_ffvec[1]), 32'h0FF);

        // Exhaustive with trojan port tied to the clean ALU
        troj_kind = 0;
        pulse_start(1'b0, 16'd0, 16'd0);
        wait_both();
        chk("clean_mm", 0, 32'(d_mm[0]), 32'd0);
        chk("clean_ffv", 0, 32'(d_ffv[0]), 32'd0);
        chk("clean_vc", 1, 32'(d_vc[1]), 32'd1024);

        // Exhaustive, many mismatches, with a stray start at vector 10
        troj_kind = 2;
        pulse_start(1'b0, 16'd0, 16'd0);
        repeat (40) @(negedge clk);
        pulse_start(1'b1, 16'd5, 16'h0042);
        wait_both();
        chk("busy_start_mm", 0, 32'(d_mm[0]), 32'd128);
        chk("busy_start_ffvec", 0, 32'(d_ffvec[0]), 32'h301);
        chk("busy_start_vc", 0, 32'(d_vc[0]), 32'd1024);

        // Random, seed 0 -> default seed, 8 vectors
        troj_kind = 1;
        pulse_start(1'b1, 16'd8, 16'd0);
        repeat (2) @(negedge clk);
        chk("lfsr_v0", 0, 32'(d_alu[0]), 32'h0E1);
        chk("lfsr_v0", 1, 32'(d_alu[1]), 32'h0E1);
        repeat (2) @(negedge clk);
        chk("lfsr_v1", 1, 32'(d_alu[1]), 32'h270);
        wait_done(1, 5, n);
        chk("rnd_latency", 1, 32'(n), 32'd18);
        chk("rnd_vc", 1, 32'(d_vc[1]), 32'd8);
        wait_done(0, n, n);

        // Reset at vector 300, then rerun from scratch
        troj_kind = 2;
        pulse_start(1'b0, 16'd0, 16'd0);
        repeat (1201) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        chk("rst_vc", 0, 32'(d_vc[0]), 32'd0);
        chk("rst_alu", 0, 32'(d_alu[0]), 32'd0);
        chk("rst_busy", 0, 32'(d_busy[0]), 32'd0);
        pulse_start(1'b0, 16'd0, 16'd0);
        wait_both();
        chk("rerun_mm", 0, 32'(d_mm[0]), 32'd128);
        chk("rerun_ffvec", 0, 32'(d_ffvec[0]), 32'h301);

        // Randomized runs
        for (int it = 0; it < 8; it++) begin
            troj_kind = $urandom_range(0, 2);
            pulse_start(1'($urandom_range(0, 1)), 16'($urandom_range(0, 60)),
                        ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(2, 20)) @(negedge clk);
                pulse_start(1'b1, 16'($urandom_range(0, 40)), 16'($urandom));
            end
            wait_both();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
